// File: rtl/doorlock_pkg.sv
// Shared definitions for the door-lock key interface: FSM state encodings,
// the released-key constant and the BCD digit to one-hot key decode.
package doorlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_ON  = 3'd1,
    ST_START_GAP = 3'd2,
    ST_KEY_ON    = 3'd3,
    ST_KEY_GAP   = 3'd4,
    ST_STOP_ON   = 3'd5,
    ST_DONE      = 3'd6
  } keyer_state_t;

  localparam logic [9:0] KEY_NONE = 10'b0;

  // Digits above 9 map to "no key" so a bad nibble can never press anything.
  function automatic logic [9:0] bcd_to_onehot(input logic [3:0] digit);
    logic [9:0] one_hot;
    one_hot = 10'd1;
    if (digit > 4'd9) begin
      one_hot = KEY_NONE;
    end else begin
      one_hot = one_hot << digit;
    end
    return one_hot;
  endfunction

endpackage

// File: rtl/doorlock_keyer_timer.sv
// Phase counter for the keyer: restarts from 0 on clear and flags the last
// cycle of a phase whose length is given by limit.
module keyer_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign last = (r_cnt == limit - W'(1));

endmodule

// File: rtl/doorlock_keyer.sv
// Replays a stored BCD code onto the lock's key inputs as a framed sequence:
// start press, one one-hot key press per digit (MSD first), stop press.
module doorlock_keyer
  import doorlock_pkg::*;
#(
  parameter int   NUM_DIGITS = 3,
  parameter int   HOLD_CYC   = 1000,
  parameter int   GAP_CYC    = 1000,
  parameter logic ACT_LVL    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go,
  input  logic [4*NUM_DIGITS-1:0] code,
  output logic [9:0]              num,
  output logic                    start,
  output logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              dbg_state
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  keyer_state_t            r_state;
  logic [4*NUM_DIGITS-1:0] r_code;
  logic [IDX_W-1:0]        r_idx;
  logic [9:0]              r_num;
  logic                    r_start;
  logic                    r_stop;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic                    w_last;
  logic                    w_clear;
  logic [TMR_W-1:0]        w_limit;
  logic                    w_code_ok;
  logic [IDX_W-1:0]        w_sel_idx;
  logic [3:0]              w_digit;

  // Gap phases use GAP_CYC, every press phase uses HOLD_CYC.
  assign w_limit = ((r_state == ST_START_GAP) || (r_state == ST_KEY_GAP)) ?
                   TMR_W'(GAP_CYC) : TMR_W'(HOLD_CYC);
  assign w_clear = (r_state == ST_IDLE) || (r_state == ST_DONE) || w_last;

  keyer_timer #(.W(TMR_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .limit (w_limit),
    .last  (w_last)
  );

  always_comb begin
    w_code_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (code[4*i +: 4] > 4'd9) w_code_ok = 1'b0;
    end
  end

  // The digit is looked up one phase early so the key press is registered
  // on the same edge that enters KEY_ON.
  assign w_sel_idx = (r_state == ST_KEY_GAP) ? r_idx + IDX_W'(1) : r_idx;

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel_idx == IDX_W'(i)) w_digit = r_code[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  // go is a valid-only request with no ready: it is taken when seen in IDLE
  // and dropped in any other state; the sender learns the outcome from
  // busy (accepted) or err (rejected) on the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_idx   <= '0;
      r_num   <= KEY_NONE;
      r_start <= ~ACT_LVL;
      r_stop  <= ~ACT_LVL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (go) begin
            if (w_code_ok) begin
              r_code  <= code;
              r_idx   <= '0;
              r_start <= ACT_LVL;
              r_busy  <= 1'b1;
              r_state <= ST_START_ON;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_START_ON: begin
          if (w_last) begin
            r_start <= ~ACT_LVL;
            r_state <= ST_START_GAP;
          end
        end
        ST_START_GAP: begin
          if (w_last) begin
            r_num   <= bcd_to_onehot(w_digit);
            r_state <= ST_KEY_ON;
          end
        end
        ST_KEY_ON: begin
          if (w_last) begin
            r_num   <= KEY_NONE;
            r_state <= ST_KEY_GAP;
          end
        end
        ST_KEY_GAP: begin
          if (w_last) begin
            if (r_idx == LAST_IDX) begin
              r_stop  <= ACT_LVL;
              r_state <= ST_STOP_ON;
            end else begin
              r_idx   <= w_sel_idx;
              r_num   <= bcd_to_onehot(w_digit);
              r_state <= ST_KEY_ON;
            end
          end
        end
        ST_STOP_ON: begin
          if (w_last) begin
            r_stop  <= ~ACT_LVL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign num       = r_num;
  assign start     = r_start;
  assign stop      = r_stop;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_doorlock_keyer.sv
// Directed bench for doorlock_keyer: cycle-by-cycle trace checks of the key
// sequence, rejected codes, ignored re-requests, mid-sequence reset, ACT_LVL=0.
module tb_doorlock_keyer;

  localparam int H = 3;
  localparam int G = 2;
  localparam int N = 3;
  localparam int W = 15;

  logic        clk;
  logic        reset;
  logic        go_a, go_b;
  logic [11:0] code_a, code_b;
  logic [9:0]  num_a, num_b;
  logic        start_a, start_b, stop_a, stop_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [2:0]  dbg_a, dbg_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  doorlock_keyer #(.NUM_DIGITS(N), .HOLD_CYC(H), .GAP_CYC(G), .ACT_LVL(1'b1)) dut_a (
    .clock(clk), .reset(reset), .go(go_a), .code(code_a), .num(num_a),
    .start(start_a), .stop(stop_a), .busy(busy_a), .done(done_a), .err(err_a),
    .dbg_state(dbg_a)
  );

  doorlock_keyer #(.NUM_DIGITS(N), .HOLD_CYC(H), .GAP_CYC(G), .ACT_LVL(1'b0)) dut_b (
    .clock(clk), .reset(reset), .go(go_b), .code(code_b), .num(num_b),
    .start(start_b), .stop(stop_b), .busy(busy_b), .done(done_b), .err(err_b),
    .dbg_state(dbg_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {num,start,stop,busy,done,err} in cycle c after go at cycle 0.
  function automatic logic [W-1:0] exp_word(input int c, input logic [11:0] cv, input logic act);
    logic [9:0] n_v;
    logic [9:0] one;
    logic [3:0] d;
    logic s_v, p_v, b_v, d_v;
    int st;
    int stop_st;
    n_v = 10'd0; one = 10'd1;
    s_v = ~act; p_v = ~act; b_v = 1'b0; d_v = 1'b0;
    if (c >= 1 && c <= H) s_v = act;
    for (int k = 0; k < N; k++) begin
      st = 1 + (H + G) * (k + 1);
      d  = cv[4*(N-1-k) +: 4];
      if (c >= st && c < st + H) n_v = one << d;
    end
    stop_st = 1 + (H + G) * (N + 1);
    if (c >= stop_st && c < stop_st + H) p_v = act;
    if (c >= 1 && c < stop_st + H) b_v = 1'b1;
    if (c == stop_st + H) d_v = 1'b1;
    return {n_v, s_v, p_v, b_v, d_v, 1'b0};
  endfunction

  function automatic logic [W-1:0] obs_word(input logic act);
    if (act) return {num_a, start_a, stop_a, busy_a, done_a, err_a};
    return {num_b, start_b, stop_b, busy_b, done_b, err_b};
  endfunction

  // Driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_go(input logic act, input logic val, input logic [11:0] cv);
    if (act) begin
      go_a = val; code_a = cv;
    end else begin
      go_b = val; code_b = cv;
    end
  endtask

  // Issues go in cycle 0, optionally a second go with alt_cv at cycle regō,
  // and checks every cycle 1..ncyc against the expected queue.
  task automatic run_trace(input string tag, input logic act, input logic [11:0] cv,
                           input int ncyc, input int rego_cyc, input logic [11:0] alt_cv,
                           output int done_cnt);
    logic [W-1:0] exp_v;
    done_cnt = 0;
    for (int c = 1; c <= ncyc; c++) exp_q.push_back(exp_word(c, cv, act));
    @(negedge clk);
    drive_go(act, 1'b1, cv);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      drive_go(act, 1'b0, (c > rego_cyc && rego_cyc > 0) ? alt_cv : cv);
      exp_v = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, c), 32'(obs_word(act)), 32'(exp_v));
      if (act ? done_a : done_b) done_cnt++;
      if (c == rego_cyc) drive_go(act, 1'b1, alt_cv);
    end
  endtask

  // Scoreboard sequence and final report
  initial begin
    int dcnt;
    reset = 1'b1;
    go_a = 1'b0; go_b = 1'b0; code_a = 12'h000; code_b = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_a", 32'(obs_word(1'b1)), 32'({10'h000, 5'b00000}));
    check("rst_b", 32'(obs_word(1'b0)), 32'({10'h000, 5'b11000}));
    check("rst_state_a", 32'(dbg_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Main sequence, code 529
    run_trace("seq529", 1'b1, 12'h529, 26, 0, 12'h000, dcnt);
    check("seq529_done_cnt", 32'(dcnt), 32'd1);

    // Code 000 with an ignored second go and a code change at cycle 10
    run_trace("seq000_rego", 1'b1, 12'h000, 26, 10, 12'h777, dcnt);
    check("seq000_done_cnt", 32'(dcnt), 32'd1);
    repeat (2) @(negedge clk);
    check("after_rego_idle", 32'(obs_word(1'b1)), 32'({10'h000, 5'b00000}));
    check("after_rego_state", 32'(dbg_a), 32'd0);

    // Invalid BCD nibble is rejected with a single err pulse
    @(negedge clk);
    drive_go(1'b1, 1'b1, 12'h5A9);
    @(negedge clk);
    drive_go(1'b1, 1'b0, 12'h5A9);
    check("bad_code_c1", 32'(obs_word(1'b1)), 32'({10'h000, 5'b00001}));
    @(negedge clk);
    check("bad_code_c2", 32'(obs_word(1'b1)), 32'({10'h000, 5'b00000}));
    @(negedge clk);
    check("bad_code_c3", 32'(obs_word(1'b1)), 32'({10'h000, 5'b00000}));

    // Reset during the second key press aborts without done
    run_trace("abort", 1'b1, 12'h529, 12, 0, 12'h000, dcnt);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_num", 32'(num_a), 32'h0);
    check("abort_busy", 32'(busy_a), 32'h0);
    check("abort_state", 32'(dbg_a), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    run_trace("restart", 1'b1, 12'h529, 26, 0, 12'h000, dcnt);
    check("restart_done_cnt", 32'(dcnt), 32'd1);

    // Active-low start/stop build
    run_trace("actlow", 1'b0, 12'h529, 26, 0, 12'h000, dcnt);
    check("actlow_done_cnt", 32'(dcnt), 32'd1);
    check("actlow_state", 32'(dbg_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/doorlock_keyer.md
Name: doorlock_keyer

Overview:
- Transmit side of the door-lock key interface.
- On a `go` request, replays a stored BCD code as a framed key sequence on the lock's input bus:
  - a start pulse,
  - one one-hot 10-bit key press per digit,
  - a stop pulse.
- Each press is held, then followed by an all-released gap, so the edge-detecting receiver registers every press exactly once.
- Used for board demo and self-test: drives the lock's `num`/`start`/`stop` inputs in place of the switches.

Parameters:
- `NUM_DIGITS`, default 3: digits per code; `code` width is 4*`NUM_DIGITS`.
- `HOLD_CYC`, default 1000: cycles each press (start, key, stop) is held active; must be ≥1.
- `GAP_CYC`, default 1000: all-released cycles after each press except the stop press; must be ≥1.
- `ACT_LVL`, default 1'b1: active level of `start`/`stop`; inactive level is ~`ACT_LVL`. Set to 1'b0 for the FPGA push-button build.

Ports:
- `clock`, input, 1: system clock.
- `reset`, input, 1: synchronous reset, active-high.
- `go`, input, 1: one-cycle request to send; sampled in IDLE only.
- `code`, input, 4*`NUM_DIGITS`: BCD digits; the most-significant nibble is sent first.
- `num`, output, 10: one-hot key bus; bit d set for digit d; all-zero means released.
- `start`, output, 1: start key, `ACT_LVL` when pressed.
- `stop`, output, 1: stop key, `ACT_LVL` when pressed.
- `busy`, output, 1: high while a sequence is being sent.
- `done`, output, 1: one-cycle pulse when the sequence completes.
- `err`, output, 1: one-cycle pulse when a request is rejected.

Behaviour:
- All outputs are registered.
- Reset (synchronous, high) sets:
  - state = IDLE, `num` = 0,
  - `start` = `stop` = ~`ACT_LVL`,
  - `busy` = `done` = `err` = 0,
  - counters = 0.
- Reset mid-sequence aborts immediately. No partial completion, no `done`.
- States: IDLE, START_ON, START_GAP, KEY_ON, KEY_GAP, STOP_ON, DONE.
- IDLE:
  - on `go`=1 with every nibble of `code` ≤ 9: latch `code`, set digit index to 0, go to START_ON.
  - on `go`=1 with any nibble > 9: stay in IDLE, pulse `err` the next cycle, drive nothing.
  - `go`=0: remain in IDLE.
- START_ON: `start` = `ACT_LVL` for `HOLD_CYC` cycles, then START_GAP.
- START_GAP: all keys released for `GAP_CYC` cycles, then KEY_ON.
- KEY_ON: `num` = one-hot of latched digit[index] for `HOLD_CYC` cycles, then KEY_GAP.
- KEY_GAP:
  - `num` = 0 for `GAP_CYC` cycles.
  - if index = `NUM_DIGITS`-1, go to STOP_ON; otherwise increment index and go to KEY_ON.
- STOP_ON: `stop` = `ACT_LVL` for `HOLD_CYC` cycles, then DONE.
- DONE: `done` = 1 and `busy` = 0 for one cycle, then IDLE.
- `busy` = 1 in every state except IDLE and DONE.
- Latency and duration:
  - outputs change in the cycle after `go` is sampled.
  - `busy` lasts exactly (`NUM_DIGITS`+2)*`HOLD_CYC` + (`NUM_DIGITS`+1)*`GAP_CYC` cycles.
- `go` while busy or in DONE is ignored, not queued.
- `code` changes after the latch do not affect the sequence in flight.
- At most one of `start`, `stop`, `num` is ever active in a cycle.
- Phase timer:
  - width = clog2(max(`HOLD_CYC`,`GAP_CYC`)+1).
  - loads 0 on each state entry.
  - the phase ends when timer = limit-1.
- Digit index width = clog2(`NUM_DIGITS`), minimum 1.

Decomposition:
- Shared package `doorlock_pkg`:
  - state encodings,
  - `KEY_NONE` = 10'b0,
  - the BCD-to-one-hot digit function, so it is shared with the receiver-side decode.
- One sub-module, `keyer_timer`: loadable phase counter with `clear` and `limit` inputs and a `last` output.
- FSM and output registers stay in `doorlock_keyer`.

Test Plan (`HOLD_CYC`=3, `GAP_CYC`=2, `NUM_DIGITS`=3, `ACT_LVL`=1 unless stated):
- `go` with `code`=12'h529 at cycle 0 ->
  - `start`=1 in cycles 1-3;
  - `num`=10'h020 in cycles 6-8, 10'h004 in 11-13, 10'h200 in 16-18;
  - `stop`=1 in cycles 21-23;
  - `done`=1 in cycle 24;
  - `busy`=1 for cycles 1-23; `num`=0 in every gap.
- `code`=12'h000 -> `num`=10'h001 in three separate press windows, each separated by ≥2 zero cycles.
- Second `go` at cycle 10 of the first sequence -> ignored; exactly one `done`, at cycle 24.
- `code`=12'h5A9 with `go` -> `err`=1 for one cycle at cycle 1; `busy`, `start`, `stop`, `num` stay inactive.
- `reset` asserted during the second KEY_ON -> next cycle `num`=0, `busy`=0, `done` never pulses; a new `go` afterwards restarts from START_ON.
- `ACT_LVL`=0 -> `start`/`stop` idle at 1 and go to 0 during their hold windows; `num` behaviour unchanged.
